// File: rtl/mcast_atomicity_monitor.sv
// mcast_atomicity_monitor
//
// Run-time checker for multicast delivery through the router crossbar. It
// watches head pops, output handshakes and per-output input selects. For each
// input it flags:
//   1 PARTIAL : some, but not all, outputs selecting the input fired
//   2 NOPOP   : an output fired from the input but its head was not popped
//   3 GHOST   : the head was popped but no output fired from it
//   4 MASK    : the fired set disagrees with the head destination mask
//               (unicast mode: the fired set is not exactly one output)
//   5 STALL   : the head stayed valid and unpopped for STALL_MAX cycles
// The first violation is latched (code, input, cycle stamp) until clear.
// Saturating counters track multicast pops and violation events.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   clear             synchronous clear of sticky error state, counters, stall timers
//   enable_mcast      1 = multicast mode, 0 = unicast mode
//   fifo_pop          per-input head pop
//   head_valid        per-input FIFO non-empty
//   dest_mask         per-input destination mask, input i at [i*NPORTS +: NPORTS]
//   out_valid/ready   per-output handshake
//   sel_in            per-output source select, output o at [o*SEL_W +: SEL_W]
//   err_valid         sticky: a violation has been captured
//   err_code/port     code and input index of the first captured violation
//   err_cycle         cycle stamp of the first captured violation
//   mcast_cnt         saturating count of multicast pops (fanout >= 2)
//   viol_cnt          saturating count of per-input violation events
//   viol_now          per-input violation pulse for the previous cycle
module mcast_atomicity_monitor #(
    parameter int NPORTS    = 5,
    parameter int SEL_W     = 3,
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     enable_mcast,
    input  logic [NPORTS-1:0]        fifo_pop,
    input  logic [NPORTS-1:0]        head_valid,
    input  logic [NPORTS*NPORTS-1:0] dest_mask,
    input  logic [NPORTS-1:0]        out_valid,
    input  logic [NPORTS-1:0]        out_ready,
    input  logic [NPORTS*SEL_W-1:0]  sel_in,
    output logic                     err_valid,
    output logic [2:0]               err_code,
    output logic [SEL_W-1:0]         err_port,
    output logic [CNT_W-1:0]         err_cycle,
    output logic [CNT_W-1:0]         mcast_cnt,
    output logic [CNT_W-1:0]         viol_cnt,
    output logic [NPORTS-1:0]        viol_now
);

    localparam int ST_W = $clog2(STALL_MAX + 1);

    localparam logic [ST_W-1:0]  ST_ZERO  = {ST_W{1'b0}};
    localparam logic [ST_W-1:0]  ST_ONE   = ST_W'(1);
    localparam logic [ST_W-1:0]  ST_PRE   = ST_W'(STALL_MAX - 1);
    localparam logic [ST_W-1:0]  ST_TOP   = ST_W'(STALL_MAX);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_TWO  = SEL_W'(2);

    // Number of set bits in an NPORTS-wide vector; NPORTS < 2^SEL_W so it fits.
    function automatic logic [SEL_W-1:0] popcnt(input logic [NPORTS-1:0] v);
        logic [SEL_W-1:0] acc;
        acc = SEL_ZERO;
        for (int k = 0; k < NPORTS; k++) begin
            acc = acc + {{(SEL_W-1){1'b0}}, v[k]};
        end
        return acc;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [SEL_W-1:0] b);
        logic [CNT_W+SEL_W-1:0] sum;
        logic [CNT_W-1:0]       res;
        sum = {{SEL_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        if (sum > {{SEL_W{1'b0}}, {CNT_W{1'b1}}}) begin
            res = {CNT_W{1'b1}};
        end else begin
            res = sum[CNT_W-1:0];
        end
        return res;
    endfunction

    // Lowest violation code present in a rule vector (bit k = code k+1).
    function automatic logic [2:0] first_code(input logic [4:0] r);
        logic [2:0] c;
        if (r[0]) begin
            c = 3'd1;
        end else if (r[1]) begin
            c = 3'd2;
        end else if (r[2]) begin
            c = 3'd3;
        end else if (r[3]) begin
            c = 3'd4;
        end else if (r[4]) begin
            c = 3'd5;
        end else begin
            c = 3'd0;
        end
        return c;
    endfunction

    // State registers
    logic [CNT_W-1:0]             cyc_q, cyc_d;
    logic [NPORTS-1:0][ST_W-1:0]  stall_q, stall_d;
    logic                         err_valid_q, err_valid_d;
    logic [2:0]                   err_code_q, err_code_d;
    logic [SEL_W-1:0]             err_port_q, err_port_d;
    logic [CNT_W-1:0]             err_cycle_q, err_cycle_d;
    logic [CNT_W-1:0]             mcast_cnt_q, mcast_cnt_d;
    logic [CNT_W-1:0]             viol_cnt_q, viol_cnt_d;
    logic [NPORTS-1:0]            viol_now_q, viol_now_d;

    // Per-cycle derived signals
    logic [NPORTS-1:0][NPORTS-1:0] v_set_s;
    logic [NPORTS-1:0][NPORTS-1:0] f_set_s;
    logic [NPORTS-1:0]             stall_hit_s;
    logic [NPORTS-1:0][4:0]        rule_s;
    logic [NPORTS-1:0]             viol_s;
    logic [NPORTS-1:0]             mc_s;
    logic [2:0]                    cap_code_s;
    logic [SEL_W-1:0]              cap_port_s;

    // Group valid and firing outputs by the input they select. A select
    // value >= NPORTS never equals a legal input index, so that output is idle.
    always_comb begin
        v_set_s = {(NPORTS*NPORTS){1'b0}};
        f_set_s = {(NPORTS*NPORTS){1'b0}};
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (sel_in[o*SEL_W +: SEL_W] == SEL_W'(i)) begin
                    v_set_s[i][o] = out_valid[o];
                    f_set_s[i][o] = out_valid[o] & out_ready[o];
                end else begin
                    v_set_s[i][o] = 1'b0;
                    f_set_s[i][o] = 1'b0;
                end
            end
        end
    end

    // Stall timers: count blocked head cycles, flag on the cycle the count
    // reaches STALL_MAX, then hold there so an episode flags only once.
    always_comb begin
        stall_d     = stall_q;
        stall_hit_s = {NPORTS{1'b0}};
        for (int i = 0; i < NPORTS; i++) begin
            stall_hit_s[i] = head_valid[i] & ~fifo_pop[i] & (stall_q[i] == ST_PRE);
            if (clear) begin
                stall_d[i] = ST_ZERO;
            end else if (!head_valid[i] || fifo_pop[i]) begin
                stall_d[i] = ST_ZERO;
            end else if (stall_q[i] != ST_TOP) begin
                stall_d[i] = stall_q[i] + ST_ONE;
            end else begin
                stall_d[i] = ST_TOP;
            end
        end
    end

    // Evaluate the five rules for every input and the multicast-pop flags.
    always_comb begin
        rule_s = {(NPORTS*5){1'b0}};
        viol_s = {NPORTS{1'b0}};
        mc_s   = {NPORTS{1'b0}};
        for (int i = 0; i < NPORTS; i++) begin
            rule_s[i][0] = (|f_set_s[i]) & (f_set_s[i] != v_set_s[i]);
            rule_s[i][1] = (|f_set_s[i]) & ~fifo_pop[i];
            rule_s[i][2] = fifo_pop[i] & ~(|f_set_s[i]);
            if (enable_mcast) begin
                rule_s[i][3] = fifo_pop[i] & (f_set_s[i] != dest_mask[i*NPORTS +: NPORTS]);
            end else begin
                rule_s[i][3] = fifo_pop[i] & (popcnt(f_set_s[i]) != SEL_ONE);
            end
            rule_s[i][4] = stall_hit_s[i];
            viol_s[i]    = |rule_s[i];
            mc_s[i]      = fifo_pop[i] & (popcnt(f_set_s[i]) >= SEL_TWO);
        end
    end

    // Pick the report for capture: scanning downward lets the lowest
    // violating input win, and first_code picks its lowest code.
    always_comb begin
        cap_code_s = 3'd0;
        cap_port_s = SEL_ZERO;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            cap_code_s = viol_s[i] ? first_code(rule_s[i]) : cap_code_s;
            cap_port_s = viol_s[i] ? SEL_W'(i) : cap_port_s;
        end
    end

    // Next state for counters and sticky capture; clear discards this
    // cycle's findings entirely. The cycle stamp keeps running through clear.
    always_comb begin
        cyc_d       = cyc_q + CNT_ONE;
        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        err_port_d  = err_port_q;
        err_cycle_d = err_cycle_q;
        mcast_cnt_d = mcast_cnt_q;
        viol_cnt_d  = viol_cnt_q;
        viol_now_d  = {NPORTS{1'b0}};
        if (clear) begin
            err_valid_d = 1'b0;
            err_code_d  = 3'd0;
            err_port_d  = SEL_ZERO;
            err_cycle_d = CNT_ZERO;
            mcast_cnt_d = CNT_ZERO;
            viol_cnt_d  = CNT_ZERO;
        end else begin
            mcast_cnt_d = sat_add(mcast_cnt_q, popcnt(mc_s));
            viol_cnt_d  = sat_add(viol_cnt_q, popcnt(viol_s));
            viol_now_d  = viol_s;
            if (!err_valid_q && (|viol_s)) begin
                err_valid_d = 1'b1;
                err_code_d  = cap_code_s;
                err_port_d  = cap_port_s;
                err_cycle_d = cyc_q;
            end else begin
                err_valid_d = err_valid_q;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q       <= CNT_ZERO;
            stall_q     <= {(NPORTS*ST_W){1'b0}};
            err_valid_q <= 1'b0;
            err_code_q  <= 3'd0;
            err_port_q  <= SEL_ZERO;
            err_cycle_q <= CNT_ZERO;
            mcast_cnt_q <= CNT_ZERO;
            viol_cnt_q  <= CNT_ZERO;
            viol_now_q  <= {NPORTS{1'b0}};
        end else begin
            cyc_q       <= cyc_d;
            stall_q     <= stall_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_port_q  <= err_port_d;
            err_cycle_q <= err_cycle_d;
            mcast_cnt_q <= mcast_cnt_d;
            viol_cnt_q  <= viol_cnt_d;
            viol_now_q  <= viol_now_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_port  = err_port_q;
    assign err_cycle = err_cycle_q;
    assign mcast_cnt = mcast_cnt_q;
    assign viol_cnt  = viol_cnt_q;
    assign viol_now  = viol_now_q;

endmodule

// File: tb/tb_mcast_atomicity_monitor.sv
// Testbench for mcast_atomicity_monitor: directed stimulus, a set-based
// reference model checked every cycle, and hand-computed literal checks.
module tb_mcast_atomicity_monitor;

    localparam int N  = 5;
    localparam int SW = 3;
    localparam int CW = 4;
    localparam int SM = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            enable_mcast = 1'b1;
    logic [N-1:0]    fifo_pop = '0;
    logic [N-1:0]    head_valid = '0;
    logic [N*N-1:0]  dest_mask = '0;
    logic [N-1:0]    out_valid = '0;
    logic [N-1:0]    out_ready = '0;
    logic [N*SW-1:0] sel_in = '1;
    logic            err_valid;
    logic [2:0]      err_code;
    logic [SW-1:0]   err_port;
    logic [CW-1:0]   err_cycle;
    logic [CW-1:0]   mcast_cnt;
    logic [CW-1:0]   viol_cnt;
    logic [N-1:0]    viol_now;

    int n_vec = 0;
    int n_miss = 0;

    mcast_atomicity_monitor #(.NPORTS(N), .SEL_W(SW), .CNT_W(CW), .STALL_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .enable_mcast(enable_mcast),
        .fifo_pop(fifo_pop), .head_valid(head_valid), .dest_mask(dest_mask),
        .out_valid(out_valid), .out_ready(out_ready), .sel_in(sel_in),
        .err_valid(err_valid), .err_code(err_code), .err_port(err_port),
        .err_cycle(err_cycle), .mcast_cnt(mcast_cnt), .viol_cnt(viol_cnt),
        .viol_now(viol_now)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit chk_en = 1'b0;
    int m_cyc, m_err_valid, m_err_code, m_err_port, m_err_cycle;
    int m_mcast, m_viol, m_vnow;
    int m_st [N];

    always @(posedge clk) begin : model
        int fset [N];
        int vset [N];
        int s, dm, nf, code, nviol, nmc, first_i, first_c, vmask, st_new;
        bit hit;
        if (!rst_n) begin
            m_cyc <= 0; m_err_valid <= 0; m_err_code <= 0; m_err_port <= 0;
            m_err_cycle <= 0; m_mcast <= 0; m_viol <= 0; m_vnow <= 0;
            for (int i = 0; i < N; i++) m_st[i] <= 0;
            chk_en <= 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin fset[i] = 0; vset[i] = 0; end
            for (int o = 0; o < N; o++) begin
                s = int'(sel_in[o*SW +: SW]);
                if (s < N) begin
                    if (out_valid[o]) vset[s] = vset[s] | (1 << o);
                    if (out_valid[o] && out_ready[o]) fset[s] = fset[s] | (1 << o);
                end
            end
            nviol = 0; nmc = 0; first_i = -1; first_c = 0; vmask = 0;
            for (int i = 0; i < N; i++) begin
                st_new = m_st[i];
                hit = 1'b0;
                if (clear) st_new = 0;
                else if (head_valid[i] && !fifo_pop[i]) begin
                    if (st_new < SM) begin
                        st_new = st_new + 1;
                        hit = (st_new == SM);
                    end
                end else st_new = 0;
                m_st[i] <= st_new;
                dm = int'(dest_mask[i*N +: N]);
                nf = $countones(fset[i]);
                code = 0;
                if (fset[i] != 0 && fset[i] != vset[i]) code = 1;
                else if (fset[i] != 0 && !fifo_pop[i]) code = 2;
                else if (fifo_pop[i] && fset[i] == 0) code = 3;
                else if (fifo_pop[i] && (enable_mcast ? (fset[i] != dm) : (nf != 1))) code = 4;
                else if (hit) code = 5;
                if (code != 0) begin
                    vmask = vmask | (1 << i);
                    nviol++;
                    if (first_i < 0) begin first_i = i; first_c = code; end
                end
                if (fifo_pop[i] && nf >= 2) nmc++;
            end
            if (clear) begin
                m_err_valid <= 0; m_err_code <= 0; m_err_port <= 0; m_err_cycle <= 0;
                m_mcast <= 0; m_viol <= 0; m_vnow <= 0;
            end else begin
                m_vnow  <= vmask;
                m_viol  <= (m_viol + nviol > CMAX) ? CMAX : m_viol + nviol;
                m_mcast <= (m_mcast + nmc > CMAX) ? CMAX : m_mcast + nmc;
                if (m_err_valid == 0 && first_i >= 0) begin
                    m_err_valid <= 1; m_err_code <= first_c;
                    m_err_port <= first_i; m_err_cycle <= m_cyc;
                end
            end
            m_cyc <= (m_cyc + 1) % (CMAX + 1);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("err_valid", 32'(err_valid), 32'(m_err_valid));
            chk("err_code",  32'(err_code),  32'(m_err_code));
            chk("err_port",  32'(err_port),  32'(m_err_port));
            chk("err_cycle", 32'(err_cycle), 32'(m_err_cycle));
            chk("mcast_cnt", 32'(mcast_cnt), 32'(m_mcast));
            chk("viol_cnt",  32'(viol_cnt),  32'(m_viol));
            chk("viol_now",  32'(viol_now),  32'(m_vnow));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fifo_pop = '0; head_valid = '0; out_valid = '0; out_ready = '0; sel_in = '1;
    endtask

    task automatic drive_out(input int o, input int s, input bit rdy);
        out_valid[o] = 1'b1;
        out_ready[o] = rdy;
        sel_in[o*SW +: SW] = SW'(s);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        idle();
        tick(); tick();
        rst_n = 1'b1;
        chk("lit_reset_err_valid", 32'(err_valid), 32'd0);
        chk("lit_reset_viol_cnt", 32'(viol_cnt), 32'd0);
        chk("lit_reset_mcast_cnt", 32'(mcast_cnt), 32'd0);

        // Good multicast: input 2 -> outputs 0,1,3, mask 01011
        enable_mcast = 1'b1;
        dest_mask[2*N +: N] = 5'b01011;
        head_valid[2] = 1'b1; fifo_pop[2] = 1'b1;
        drive_out(0, 2, 1'b1); drive_out(1, 2, 1'b1); drive_out(3, 2, 1'b1);
        tick();
        chk("lit_good_viol_now", 32'(viol_now), 32'd0);
        chk("lit_good_mcast", 32'(mcast_cnt), 32'd1);
        chk("lit_good_err_valid", 32'(err_valid), 32'd0);

        // Partial multicast: output 3 not ready
        out_ready[3] = 1'b0;
        tick();
        chk("lit_partial_code", 32'(err_code), 32'd1);
        chk("lit_partial_port", 32'(err_port), 32'd2);
        chk("lit_partial_viol_cnt", 32'(viol_cnt), 32'd1);
        chk("lit_partial_viol_now", 32'(viol_now), 32'b00100);
        chk("lit_partial_mcast", 32'(mcast_cnt), 32'd2);
        idle();
        tick();
        chk("lit_pulse_gone", 32'(viol_now), 32'd0);

        // Ghost on inputs 1 and 4; lowest input reported
        do_clear();
        chk("lit_clear_err_valid", 32'(err_valid), 32'd0);
        fifo_pop = 5'b10010;
        tick();
        chk("lit_ghost_code", 32'(err_code), 32'd3);
        chk("lit_ghost_port", 32'(err_port), 32'd1);
        chk("lit_ghost_viol_cnt", 32'(viol_cnt), 32'd2);
        chk("lit_ghost_viol_now", 32'(viol_now), 32'b10010);
        idle();

        // Out-of-range selects are ignored
        do_clear();
        drive_out(0, 5, 1'b1); drive_out(1, 7, 1'b1);
        tick();
        chk("lit_oor_viol_now", 32'(viol_now), 32'd0);
        idle();

        // NOPOP: output 2 fires from input 1 without a pop
        drive_out(2, 1, 1'b1);
        tick();
        chk("lit_nopop_code", 32'(err_code), 32'd2);
        chk("lit_nopop_port", 32'(err_port), 32'd1);
        idle();

        // Unicast mode: good single delivery, then a 2-way delivery
        do_clear();
        enable_mcast = 1'b0;
        fifo_pop[3] = 1'b1; drive_out(4, 3, 1'b1);
        tick();
        chk("lit_uni_ok_viol_now", 32'(viol_now), 32'd0);
        chk("lit_uni_ok_err_valid", 32'(err_valid), 32'd0);
        idle();
        fifo_pop[0] = 1'b1; drive_out(1, 0, 1'b1); drive_out(2, 0, 1'b1);
        tick();
        chk("lit_uni_code", 32'(err_code), 32'd4);
        chk("lit_uni_port", 32'(err_port), 32'd0);
        chk("lit_uni_mcast", 32'(mcast_cnt), 32'd1);
        idle();

        // Stall on input 4 with STALL_MAX=4
        enable_mcast = 1'b1;
        dest_mask[4*N +: N] = 5'b00001;
        do_clear();
        head_valid[4] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("lit_stall_early", 32'(viol_now), 32'd0);
        end
        tick();
        chk("lit_stall_flag", 32'(viol_now), 32'b10000);
        chk("lit_stall_code", 32'(err_code), 32'd5);
        chk("lit_stall_port", 32'(err_port), 32'd4);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("lit_stall_noreflag", 32'(viol_now), 32'd0);
        end
        fifo_pop[4] = 1'b1; drive_out(0, 4, 1'b1);
        tick();
        chk("lit_stall_pop", 32'(viol_now), 32'd0);
        fifo_pop = '0; out_valid = '0; out_ready = '0; sel_in = '1;
        for (int k = 0; k < 3; k++) tick();
        tick();
        chk("lit_stall2_flag", 32'(viol_now), 32'b10000);
        chk("lit_stall2_cnt", 32'(viol_cnt), 32'd2);
        idle();

        // Saturation with 20 ghost cycles
        do_clear();
        fifo_pop[0] = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("lit_sat_viol_cnt", 32'(viol_cnt), 32'd15);
        chk("lit_sat_code", 32'(err_code), 32'd3);
        // Clear coinciding with a violation wins
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("lit_clrwin_err_valid", 32'(err_valid), 32'd0);
        chk("lit_clrwin_viol_cnt", 32'(viol_cnt), 32'd0);
        chk("lit_clrwin_viol_now", 32'(viol_now), 32'd0);
        tick();
        chk("lit_after_clr_err_valid", 32'(err_valid), 32'd1);
        // One-cycle reset wipes everything
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("lit_rst_err_valid", 32'(err_valid), 32'd0);
        chk("lit_rst_viol_cnt", 32'(viol_cnt), 32'd0);
        chk("lit_rst_err_code", 32'(err_code), 32'd0);
        chk("lit_rst_viol_now", 32'(viol_now), 32'd0);
        idle();
        tick(); tick();
        chk("lit_end_err_valid", 32'(err_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
